// File: rtl/symbol_packer_if.sv
// Stream bundle between the narrow symbol source and the wide-beat consumer of symbol_packer.
// The master side drives symbols in and accepts wide beats; the slave side is the packer.
interface symbol_packer_if #(
  parameter int BITS_PER_SYMBOL = 20,
  parameter int OUT_SYMBOLS     = 4,
  parameter int EMPTY_WIDTH     = $clog2(OUT_SYMBOLS)
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [BITS_PER_SYMBOL-1:0]           in_data;
  logic                                 in_sop;
  logic                                 in_eop;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [BITS_PER_SYMBOL*OUT_SYMBOLS-1:0] out_data;
  logic                                 out_sop;
  logic                                 out_eop;
  logic [EMPTY_WIDTH-1:0]               out_empty;
  logic [31:0]                          pkt_cnt;
  logic [15:0]                          err_cnt;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_empty, pkt_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_empty, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/symbol_packer.sv
// Packs a one-symbol-per-beat packet stream into OUT_SYMBOLS-wide beats with aligned sop/eop/empty,
// dropping and counting symbols that break packet framing.
module symbol_packer #(
  parameter int BITS_PER_SYMBOL = 20,
  parameter int OUT_SYMBOLS     = 4,
  parameter int EMPTY_WIDTH     = $clog2(OUT_SYMBOLS)
) (
  input logic           clk,
  input logic           rst,
  symbol_packer_if.slave bus
);
  localparam int W = BITS_PER_SYMBOL;
  localparam int N = OUT_SYMBOLS;
  localparam logic [EMPTY_WIDTH-1:0] LAST = EMPTY_WIDTH'(N - 1);

  typedef enum logic {IDLE, PKT} state_e;

  state_e                 state_q;
  logic [EMPTY_WIDTH-1:0] cnt_q;
  logic                   first_q;
  logic [W-1:0]           acc_q [N-1];
  logic                   out_valid_q;
  logic                   out_sop_q;
  logic                   out_eop_q;
  logic [W*N-1:0]         out_data_q;
  logic [EMPTY_WIDTH-1:0] out_empty_q;
  logic [31:0]            pkt_cnt_q;
  logic [15:0]            err_cnt_q;

  logic                   in_rdy;
  logic                   in_fire;
  logic                   out_fire;
  logic                   start;
  logic                   cont;
  logic                   err_ev;
  logic                   complete;
  logic [EMPTY_WIDTH-1:0] lane;
  logic [W*N-1:0]         out_data_d;
  logic [EMPTY_WIDTH-1:0] out_empty_d;
  logic                   out_sop_d;

  // A sop symbol always restarts the packet; in PKT that means the open packet lost its eop.
  always_comb begin
    in_rdy      = !out_valid_q || bus.out_ready;
    in_fire     = bus.in_valid && in_rdy;
    out_fire    = out_valid_q && bus.out_ready;
    start       = in_fire && bus.in_sop;
    cont        = in_fire && !bus.in_sop && (state_q == PKT);
    err_ev      = (in_fire && !bus.in_sop && (state_q == IDLE)) || (start && (state_q == PKT));
    lane        = start ? '0 : cnt_q;
    complete    = (start && bus.in_eop) || (cont && (bus.in_eop || (cnt_q == LAST)));
    out_sop_d   = start || first_q;
    out_empty_d = bus.in_eop ? (LAST - lane) : '0;
    out_data_d  = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (i < int'(lane)) out_data_d[(N-1-i)*W +: W] = acc_q[i];
    end
    out_data_d[(N-1-int'(lane))*W +: W] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      for (int i = 0; i < N - 1; i++) acc_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_empty_q <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      if ((start || cont) && (lane != LAST)) acc_q[lane] <= bus.in_data;

      case (state_q)
        IDLE: if (start) state_q <= bus.in_eop ? IDLE : PKT;
        PKT: begin
          if (start)                    state_q <= bus.in_eop ? IDLE : PKT;
          else if (cont && bus.in_eop)  state_q <= IDLE;
        end
      endcase

      if (complete)   cnt_q <= '0;
      else if (start) cnt_q <= EMPTY_WIDTH'(1);
      else if (cont)  cnt_q <= cnt_q + 1'b1;

      if (complete)   first_q <= 1'b0;
      else if (start) first_q <= 1'b1;

      // Completion may coincide with the downstream taking the previous beat.
      if (complete) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_sop_q   <= out_sop_d;
        out_eop_q   <= bus.in_eop;
        out_empty_q <= out_empty_d;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end

      if (out_fire && out_eop_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (err_ev && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_empty = out_empty_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/symbol_packer.md
# symbol_packer

- Consumes the narrow symbol stream from the infill FIFO wrapper's output port (1 symbol/beat, sop/eop sampled on fire).
- Packs consecutive symbols into wide beats of OUT_SYMBOLS symbols with packet-aligned sop/eop/empty for the downstream wide datapath (rule matcher input).
- Enforces packet framing: malformed symbols are dropped and counted.

## Interface
Parameters:
- BITS_PER_SYMBOL, 20, width of one symbol.
- OUT_SYMBOLS, 4, symbols per output beat; power of two, ≥2.
- EMPTY_WIDTH, $clog2(OUT_SYMBOLS), width of out_empty.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream symbol valid.
- in_ready  out  1  symbol accepted when in_valid && in_ready.
- in_data  in  BITS_PER_SYMBOL  symbol.
- in_sop  in  1  first symbol of packet; meaningful only on in fire.
- in_eop  in  1  last symbol of packet; meaningful only on in fire.
- out_valid  out  1  wide beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  BITS_PER_SYMBOL*OUT_SYMBOLS  symbol 0 in MSBs.
- out_sop  out  1  first beat of packet.
- out_eop  out  1  last beat of packet.
- out_empty  out  EMPTY_WIDTH  unused trailing symbol lanes; nonzero only with out_eop.
- pkt_cnt  out  32  packets emitted (out fire with out_eop); wraps.
- err_cnt  out  16  framing errors; saturates at 16'hFFFF.

## Operation
- Symbol fire = in_valid && in_ready. Out fire = out_valid && out_ready.
- in_ready = !out_valid || out_ready; no dependence on in_valid/in_data.
- Internal: accumulator (OUT_SYMBOLS-1 symbol slots), lane counter cnt (0..OUT_SYMBOLS-1), first_beat flag, output register (data/sop/eop/empty/valid).
- FSM, two states:
  - IDLE: waits for sop. Fire with in_sop: write symbol to lane 0, first_beat=1, go PKT; if in_eop also set, complete at once (single-symbol packet). Fire without in_sop: drop symbol, err_cnt+1, stay IDLE.
  - PKT: fire without in_sop writes lane cnt. Beat completes when cnt==OUT_SYMBOLS-1 or in_eop. On completion, load output register: out_sop=first_beat, out_eop=in_eop, out_empty = in_eop ? OUT_SYMBOLS-1-cnt : 0; unused lanes zero; cnt→0; first_beat→0. in_eop → IDLE, else stay PKT.
  - PKT, fire with in_sop (missing eop): discard accumulator, err_cnt+1, treat symbol as new sop exactly as in IDLE (lane 0, first_beat=1, eop handling identical).
- Full beat not ending packet: out_eop=0, out_empty=0.
- Output register holds until out fire; out fire with no new completion clears out_valid; out fire and completion in the same cycle reloads (out_valid stays 1).
- pkt_cnt increments on out fire with out_eop=1.

## Timing
- Reset values: out_valid=0, out_data=0, out_sop=0, out_eop=0, out_empty=0, pkt_cnt=0, err_cnt=0; in_ready=1 after reset; state IDLE, cnt=0, first_beat=0, accumulator cleared.
- Reset mid-packet: partial beat and pending output beat discarded silently; no error counted.
- Latency: completing symbol fired at edge k → out_valid=1 in cycle after edge k.
- Throughput: one symbol/cycle while out_ready=1; full wide beat every OUT_SYMBOLS cycles.
- Backpressure: out_valid && !out_ready → in_ready=0; out_* stable until fire.
- Counters update on the same edge as the triggering fire; err_cnt at 16'hFFFF stays.

## Test plan
- OUT_SYMBOLS=4, 8-symbol packet 0x00001..0x00008, out_ready=1 → two beats: {1,2,3,4} sop=1 eop=0 empty=0; {5,6,7,8} sop=0 eop=1 empty=0; pkt_cnt=1.
- 6-symbol packet → beat 2 = {5,6,0,0}, eop=1, empty=2; single-symbol packet (sop+eop) 0xABCDE → {0xABCDE,0,0,0} sop=eop=1 empty=3.
- out_ready held 0 for 10 cycles after first beat of 12-symbol packet → in_ready=0 after the cycle where that beat loads; out_data stable; release → remaining beats in order, no loss.
- 3 symbols without sop in IDLE → nothing output, err_cnt=3; then 2-symbol packet with sop at 2nd symbol of a 3-symbol open packet → partial discarded, err_cnt=4, next beat sop=1.
- Back-to-back 4-symbol packets, out_ready=1 → one beat every 4 cycles, each sop=eop=1 empty=0, no bubble; assert rst mid-packet → out_valid=0 next cycle, counters 0.
